lfsr_window_gen: RTL and testbench

//  Pseudo-random serial bit source feeding the codeword-detector FSM. A Fibonacci LFSR

---
 rtl/lfsr_window_gen.sv | 134 +++++++++++++
 tb/tb_lfsr_window_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_window_gen.sv
// Fibonacci LFSR serial bit source with a per-window boundary tick.
// A small IDLE/RUN/DONE controller handles start, halt, seed load and finite runs.
module lfsr_window_gen #(
    parameter int                LFSR_W      = 15,
    parameter logic [LFSR_W-1:0] TAPS        = 15'h6000,
    parameter logic [LFSR_W-1:0] SEED        = 15'h0001,
    parameter int                WINDOW_LEN  = 1000,
    parameter int                CNT_W       = 10,
    parameter int                NUM_WINDOWS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              lfsr_output,
    output logic              bit_valid,
    output logic              max_tick_reg,
    output logic [15:0]       window_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(WINDOW_LEN - 1);
    localparam logic [15:0]      WINDOWS_END = 16'(NUM_WINDOWS);

    state_t              state_reg, state_next;
    logic [LFSR_W-1:0]   lfsr_reg, lfsr_next;
    logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [15:0]         window_idx_reg, window_idx_next;
    logic                max_tick_next;

    logic [LFSR_W-1:0]   tap_bits;
    logic                feedback;
    logic                boundary;
    logic                last_window;
    logic [LFSR_W-1:0]   seed_value;

    generate
        for (genvar gi = 0; gi < LFSR_W; gi++) begin : g_taps
            assign tap_bits[gi] = lfsr_reg[gi] & TAPS[gi];
        end
    endgenerate

    assign feedback    = ^tap_bits;
    assign boundary    = (bit_cnt_reg == CNT_LAST);
    assign last_window = (NUM_WINDOWS != 0) && ((window_idx_reg + 16'd1) == WINDOWS_END);
    // A zero seed would lock the LFSR, so it falls back to the default seed.
    assign seed_value  = (seed_in == '0) ? SEED : seed_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            lfsr_reg       <= SEED;
            bit_cnt_reg    <= '0;
            window_idx_reg <= '0;
            max_tick_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            bit_cnt_reg    <= bit_cnt_next;
            window_idx_reg <= window_idx_next;
            max_tick_reg   <= max_tick_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (!seed_load && start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (halt) begin
                    state_next = IDLE;
                end else if (boundary && last_window) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        lfsr_next       = lfsr_reg;
        bit_cnt_next    = bit_cnt_reg;
        window_idx_next = window_idx_reg;
        max_tick_next   = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (seed_load) begin
                    lfsr_next = seed_value;
                end else if (start) begin
                    bit_cnt_next    = '0;
                    window_idx_next = '0;
                end
            end
            RUN: begin
                // Halt wins over a coincident boundary: no tick, index untouched.
                if (!halt) begin
                    if (!(boundary && last_window)) begin
                        lfsr_next = {lfsr_reg[LFSR_W-2:0], feedback};
                    end
                    if (boundary) begin
                        bit_cnt_next    = '0;
                        window_idx_next = window_idx_reg + 16'd1;
                        max_tick_next   = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        lfsr_output = lfsr_reg[LFSR_W-1];
        bit_valid   = (state_reg == RUN);
        busy        = (state_reg == RUN);
        done        = (state_reg == DONE);
        window_idx  = window_idx_reg;
    end

endmodule

// File: tb/tb_lfsr_window_gen.sv
// Directed bench for lfsr_window_gen: a default-parameter instance and a short-window
// finite-run instance, the latter checked cycle by cycle against a queued reference model.
module tb_lfsr_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start_a, halt_a, seed_load_a;
    logic [14:0] seed_in_a;
    logic        lfsr_output_a, bit_valid_a, max_tick_a, busy_a, done_a;
    logic [15:0] window_idx_a;

    logic        start_b, halt_b, seed_load_b;
    logic [14:0] seed_in_b;
    logic        lfsr_output_b, bit_valid_b, max_tick_b, busy_b, done_b;
    logic [15:0] window_idx_b;

    lfsr_window_gen dut_a (
        .clk         (clk),
        .rst         (rst),
        .start       (start_a),
        .halt        (halt_a),
        .seed_load   (seed_load_a),
        .seed_in     (seed_in_a),
        .lfsr_output (lfsr_output_a),
        .bit_valid   (bit_valid_a),
        .max_tick_reg(max_tick_a),
        .window_idx  (window_idx_a),
        .busy        (busy_a),
        .done        (done_a)
    );

    lfsr_window_gen #(
        .WINDOW_LEN (8),
        .CNT_W      (3),
        .NUM_WINDOWS(3)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .start       (start_b),
        .halt        (halt_b),
        .seed_load   (seed_load_b),
        .seed_in     (seed_in_b),
        .lfsr_output (lfsr_output_b),
        .bit_valid   (bit_valid_b),
        .max_tick_reg(max_tick_b),
        .window_idx  (window_idx_b),
        .busy        (busy_b),
        .done        (done_b)
    );

    int total = 0;
    int bad   = 0;
    int ticks = 0;

    logic [20:0] exp_q[$];

    // Reference model of instance b (window of 8 bits, 3 windows per run)
    int          m_state;  // 0 idle, 1 run, 2 done
    logic [14:0] m_lfsr;
    int          m_cnt;
    logic [15:0] m_idx;
    logic        m_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [20:0] obs_a();
        return {lfsr_output_a, bit_valid_a, max_tick_a, window_idx_a, busy_a, done_a};
    endfunction

    function automatic logic [20:0] obs_b();
        return {lfsr_output_b, bit_valid_b, max_tick_b, window_idx_b, busy_b, done_b};
    endfunction

    function automatic logic [20:0] model_out();
        return {m_lfsr[14], m_state == 1, m_tick, m_idx, m_state == 1, m_state == 2};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_lfsr  = 15'h0001;
        m_cnt   = 0;
        m_idx   = 16'd0;
        m_tick  = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic h, input logic sl, input logic [14:0] si);
        logic last;
        m_tick = 1'b0;
        if (m_state == 1) begin
            if (!h) begin
                last = (m_cnt == 7);
                if (last) begin
                    m_cnt  = 0;
                    m_tick = 1'b1;
                    if (m_idx == 16'd2) m_state = 2;
                    else m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
                    m_idx = m_idx + 16'd1;
                end else begin
                    m_cnt  = m_cnt + 1;
                    m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
                end
            end else begin
                m_state = 0;
            end
        end else if (sl) begin
            m_lfsr = (si == 15'd0) ? 15'h0001 : si;
        end else if (s) begin
            m_state = 1;
            m_cnt   = 0;
            m_idx   = 16'd0;
        end
    endtask

    task automatic cyc_b(input logic s, input logic h, input logic sl, input logic [14:0] si);
        logic [20:0] want;
        start_b     = s;
        halt_b      = h;
        seed_load_b = sl;
        seed_in_b   = si;
        model_step(s, h, sl, si);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        chk("sb_b", 32'(obs_b()), 32'(want));
        start_b     = 1'b0;
        halt_b      = 1'b0;
        seed_load_b = 1'b0;
    endtask

    task automatic tick_a();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        start_a     = 1'b0; halt_a = 1'b0; seed_load_a = 1'b0; seed_in_a = '0;
        start_b     = 1'b0; halt_b = 1'b0; seed_load_b = 1'b0; seed_in_b = '0;
        model_reset();
        #2;
        chk("reset_a", 32'(obs_a()), 32'd0);
        chk("reset_b", 32'(obs_b()), 32'd0);
        #10;
        rst = 1'b0;
        tick_a();

        // Finite run: ticks at cycles 8, 16, 24, DONE from 24, frozen after
        cyc_b(1'b1, 1'b0, 1'b0, 15'd0);
        for (int c = 1; c <= 30; c++) begin
            cyc_b(1'b0, 1'b0, 1'b0, 15'd0);
            if (c == 8 || c == 16 || c == 24)
                chk("t2_tick", {max_tick_b, window_idx_b}, {1'b1, 16'(c / 8)});
            if (c == 24)
                chk("t2_done", {done_b, busy_b}, 2'b10);
        end

        // Restart from DONE, halt at bit 5 of window 2
        cyc_b(1'b1, 1'b0, 1'b0, 15'd0);
        for (int c = 1; c <= 13; c++) cyc_b(1'b0, 1'b0, 1'b0, 15'd0);
        cyc_b(1'b0, 1'b1, 1'b0, 15'd0);
        chk("t4_halt", {busy_b, max_tick_b, window_idx_b}, {1'b0, 1'b0, 16'd1});
        cyc_b(1'b1, 1'b0, 1'b0, 15'd0);
        chk("t4_restart", {busy_b, window_idx_b}, {1'b1, 16'd0});

        // Halt coincident with the end of window 2
        for (int c = 1; c <= 15; c++) cyc_b(1'b0, 1'b0, 1'b0, 15'd0);
        cyc_b(1'b0, 1'b1, 1'b0, 15'd0);
        chk("t5_halt_bnd", {busy_b, max_tick_b, window_idx_b}, {1'b0, 1'b0, 16'd1});

        // Seed load in DONE after a full run, then start continues from it
        cyc_b(1'b1, 1'b0, 1'b0, 15'd0);
        for (int c = 1; c <= 24; c++) cyc_b(1'b0, 1'b0, 1'b0, 15'd0);
        cyc_b(1'b1, 1'b0, 1'b1, 15'h7FFF);
        chk("done_seed", {done_b, lfsr_output_b}, 2'b11);
        cyc_b(1'b1, 1'b0, 1'b0, 15'd0);
        for (int c = 1; c <= 4; c++) cyc_b(1'b0, 1'b0, 1'b0, 15'd0);

        // Asynchronous reset between edges while a tick is showing
        cyc_b(1'b0, 1'b1, 1'b0, 15'd0);
        cyc_b(1'b1, 1'b0, 1'b0, 15'd0);
        for (int c = 1; c <= 8; c++) cyc_b(1'b0, 1'b0, 1'b0, 15'd0);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_rst", 32'(obs_b()), 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick_a();
        cyc_b(1'b1, 1'b0, 1'b0, 15'd0);
        for (int c = 1; c <= 10; c++) cyc_b(1'b0, 1'b0, 1'b0, 15'd0);
        chk("q_empty", 32'(exp_q.size()), 32'd0);

        // Default instance: first 15 bits, window ticks, full period
        start_a = 1'b1;
        tick_a();
        start_a = 1'b0;
        ticks = 0;
        for (int c = 0; c <= 32781; c++) begin
            if (c <= 14) chk("t1_bit", 32'(lfsr_output_a), 32'(c == 14));
            if (c >= 32767 && c <= 32781) chk("t1_period", 32'(lfsr_output_a), 32'(c == 32781));
            if (max_tick_a) ticks++;
            if (c == 999) chk("t1_tick999", {max_tick_a, window_idx_a}, {1'b0, 16'd0});
            if (c == 1000) chk("t1_tick1000", {max_tick_a, window_idx_a}, {1'b1, 16'd1});
            if (c == 32767) begin
                chk("t1_nticks", 32'(ticks), 32'd32);
                chk("t1_idx", 32'(window_idx_a), 32'd32);
            end
            tick_a();
        end
        halt_a = 1'b1;
        tick_a();
        halt_a = 1'b0;
        chk("t1_halt", {busy_a, bit_valid_a, done_a}, 3'b000);

        // Seed loading in IDLE
        seed_load_a = 1'b1;
        seed_in_a   = 15'h7FFF;
        tick_a();
        chk("t3_seed7fff", 32'(lfsr_output_a), 32'd1);
        seed_in_a = 15'd0;
        tick_a();
        chk("t3_seed0", 32'(lfsr_output_a), 32'd0);
        seed_load_a = 1'b0;
        start_a     = 1'b1;
        tick_a();
        start_a = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            if (c == 0 || c == 13 || c == 14) chk("t3_zero_sub", 32'(lfsr_output_a), 32'(c == 14));
            tick_a();
        end
        halt_a = 1'b1;
        tick_a();
        halt_a      = 1'b0;
        seed_load_a = 1'b1;
        start_a     = 1'b1;
        seed_in_a   = 15'h7FFF;
        tick_a();
        chk("t3_load_start", {busy_a, lfsr_output_a}, 2'b01);
        seed_load_a = 1'b0;
        tick_a();
        start_a = 1'b0;
        chk("t3_run_after", {busy_a, bit_valid_a, lfsr_output_a, window_idx_a}, {3'b111, 16'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
